// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the adder-sharing scheduler slice.
package adder_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned OPERAND_W       = 8;
  localparam int unsigned NUM_OPERANDS    = 8;
  localparam int unsigned RESULT_W        = 11;
  localparam int unsigned DEFAULT_ADD_LAT = 5;
  localparam int unsigned SET_W           = OPERAND_W * NUM_OPERANDS;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester, adder and response bus shared by the scheduler and its neighbours.
interface adder_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  import adder_share_arbiter_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*SET_W-1:0] req_operands;
  logic [SET_W-1:0]         add_operands;
  logic                     add_valid;
  logic [RESULT_W-1:0]      add_result;
  logic                     add_valid_out;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [RESULT_W-1:0]      rsp_result;

  // master: requesters plus adder; slave: the scheduler
  modport master (
    output req_valid, req_operands, add_result, add_valid_out,
    input  req_ready, add_operands, add_valid, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_operands, add_result, add_valid_out,
    output req_ready, add_operands, add_valid, rsp_valid, rsp_id, rsp_result
  );

endinterface

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int unsigned IW = $clog2(N);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one fixed-latency pipelined adder among NUM_REQ requesters and routes
// each result back to its issuer via a tag pipeline matched to the adder latency.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADD_LAT = DEFAULT_ADD_LAT,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  adder_share_arbiter_if.slave  bus,
  output logic                  idle,
  output logic                  err
);

  localparam int unsigned CNT_W = $clog2(ADD_LAT + 2);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic [SET_W-1:0]    grant_ops;
  logic                hs;

  logic [SET_W-1:0]    add_operands_q;
  logic                add_valid_q;
  logic [ID_W-1:0]     add_id_q;

  logic [ADD_LAT-1:0]  tag_vld_q;
  logic [ID_W-1:0]     tag_id_q [ADD_LAT];
  logic                tail_vld;
  logic [ID_W-1:0]     tail_id;
  logic                rsp_load;
  logic [NUM_REQ-1:0]  rsp_onehot;

  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [RESULT_W-1:0] rsp_result_q;
  logic                err_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req      (bus.req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign bus.req_ready = (state_q == RUN) ? grant : '0;
  assign hs            = |(bus.req_valid & bus.req_ready);
  assign grant_ops     = bus.req_operands[grant_id*SET_W +: SET_W];

  assign tail_vld   = tag_vld_q[ADD_LAT-1];
  assign tail_id    = tag_id_q[ADD_LAT-1];
  assign rsp_load   = bus.add_valid_out & tail_vld;
  assign rsp_onehot = NUM_REQ'(1) << tail_id;

  always_comb begin
    ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    unique case ({hs, rsp_load})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      // re-enable wins over completing the drain
      DRAIN:   if (enable) state_d = RUN;
               else if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      cnt_q          <= '0;
      add_valid_q    <= 1'b0;
      add_operands_q <= '0;
      add_id_q       <= '0;
      tag_vld_q      <= '0;
      for (int unsigned i = 0; i < ADD_LAT; i++) tag_id_q[i] <= '0;
      rsp_valid_q    <= '0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_valid_q <= hs;
      if (hs) begin
        ptr_q          <= ptr_d;
        add_operands_q <= grant_ops;
        add_id_q       <= grant_id;
      end

      // Tag entry i pairs with adder stage i; the tail lines up with add_valid_out
      tag_vld_q   <= {tag_vld_q[ADD_LAT-2:0], add_valid_q};
      tag_id_q[0] <= add_id_q;
      for (int unsigned i = 1; i < ADD_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];

      rsp_valid_q <= rsp_load ? rsp_onehot : '0;
      if (rsp_load) begin
        rsp_id_q     <= tail_id;
        rsp_result_q <= bus.add_result;
      end
      if (bus.add_valid_out != tail_vld) err_q <= 1'b1;
    end
  end

  assign bus.add_operands = add_operands_q;
  assign bus.add_valid    = add_valid_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign idle             = (state_q == IDLE) && (cnt_q == '0);
  assign err              = err_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench: directed operand sets with hand-computed sums, a behavioural
// 5-stage adder, and independent grant/response monitors.
module tb_adder_share_arbiter;
  import adder_share_arbiter_pkg::*;

  localparam int unsigned NR  = 4;
  localparam int unsigned LAT = 5;
  localparam int unsigned IDW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic idle, err;
  logic force_vo = 1'b0;

  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NUM_REQ(NR), .ID_W(IDW)) bus ();

  adder_share_arbiter #(.NUM_REQ(NR), .ADD_LAT(LAT), .ID_W(IDW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus),
    .idle   (idle),
    .err    (err)
  );

  // Behavioural adder sharing rst_n
  logic [LAT-1:0] av_q;
  logic [10:0]    as_q [LAT];

  function automatic logic [10:0] sum8(input logic [63:0] ops);
    logic [10:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + 11'(ops[8*i +: 8]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      av_q <= '0;
      for (int i = 0; i < LAT; i++) as_q[i] <= '0;
    end else begin
      av_q    <= {av_q[LAT-2:0], bus.add_valid};
      as_q[0] <= sum8(bus.add_operands);
      for (int i = 1; i < LAT; i++) as_q[i] <= as_q[i-1];
    end
  end

  assign bus.add_valid_out = av_q[LAT-1] | force_vo;
  assign bus.add_result    = as_q[LAT-1];

  // Stimulus buffers and scoreboard
  typedef struct {
    int unsigned id;
    int unsigned sum;
  } exp_t;

  logic [63:0]  rbuf [NR][16];
  int unsigned  rhead [NR];
  int unsigned  rtail [NR];
  exp_t         exp_rsp[$];
  int unsigned  exp_grant[$];
  int unsigned  exp_cyc[$];
  int unsigned  cyc = 0;
  int unsigned  n_cmp = 0;
  int unsigned  n_fail = 0;
  int unsigned  n_rsp = 0;
  int unsigned  n_grant = 0;
  int unsigned  peak = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]            = (rhead[i] != rtail[i]);
      bus.req_operands[64*i +: 64] = rbuf[i][rhead[i] % 16];
    end
  endtask

  task automatic push_req(input int unsigned id, input logic [63:0] ops);
    rbuf[id][rtail[id] % 16] = ops;
    rtail[id]++;
  endtask

  task automatic expect_op(input int unsigned id, input int unsigned sum);
    exp_t e;
    e.id  = id;
    e.sum = sum;
    exp_grant.push_back(id);
    exp_rsp.push_back(e);
  endtask

  function automatic logic [63:0] seq_ops(input logic [7:0] start);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = start + 8'(i);
    return v;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    exp_rsp.delete();
    exp_grant.delete();
    exp_cyc.delete();
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    clear_all();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_req_ready"},    64'(bus.req_ready),    64'd0);
    chk({p, "_add_valid"},    64'(bus.add_valid),    64'd0);
    chk({p, "_add_operands"}, bus.add_operands,      64'd0);
    chk({p, "_rsp_valid"},    64'(bus.rsp_valid),    64'd0);
    chk({p, "_rsp_id"},       64'(bus.rsp_id),       64'd0);
    chk({p, "_rsp_result"},   64'(bus.rsp_result),   64'd0);
    chk({p, "_err"},          64'(err),              64'd0);
    chk({p, "_idle"},         64'(idle),             64'd1);
  endtask

  task automatic wait_all(input int unsigned max, input string name);
    for (int unsigned i = 0; i < max; i++) begin
      @(negedge clk);
      if (exp_rsp.size() == 0 && exp_grant.size() == 0) break;
    end
    chk(name, 64'(exp_rsp.size() + exp_grant.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Requester driver: retire a handshaked entry just after the edge
  initial begin
    logic [NR-1:0] hs;
    forever begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (hs[i] && rhead[i] != rtail[i]) rhead[i]++;
      refresh();
    end
  end

  // Grant monitor
  initial begin
    logic [NR-1:0] g;
    int unsigned   e;
    forever begin
      @(negedge clk);
      g = bus.req_valid & bus.req_ready;
      if (rst_n && g != '0) begin
        n_grant++;
        if (exp_grant.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_grant: req_ready=%b expected none (cycle %0d)", g, cyc);
        end else begin
          e = exp_grant.pop_front();
          chk("grant_order", 64'(g), 64'(NR'(1) << e));
        end
        exp_cyc.push_back(cyc + 7);
      end
    end
  end

  // Response monitor
  initial begin
    exp_t        e;
    int unsigned c;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid != '0) begin
        n_rsp++;
        if (exp_rsp.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=%b rsp_id=%0d rsp_result=%0d expected none",
                   bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_valid",  64'(bus.rsp_valid),  64'(NR'(1) << e.id));
          chk("rsp_id",     64'(bus.rsp_id),     64'(e.id));
          chk("rsp_result", 64'(bus.rsp_result), 64'(e.sum));
        end
        if (exp_cyc.size() > 0) begin
          c = exp_cyc.pop_front();
          chk("rsp_latency", 64'(cyc), 64'(c));
        end
      end
    end
  end

  always @(negedge clk)
    if (32'(dut.cnt_q) > peak) peak = 32'(dut.cnt_q);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned sums4 [4];
    int unsigned nb;
    sums4 = '{36, 44, 52, 60};
    bus.req_operands = '0;
    clear_all();

    do_reset();
    @(negedge clk);
    chk_reset("por");

    // Single request, all operands 255
    push_req(2, {8{8'd255}});
    expect_op(2, 2040);
    enable = 1'b1;
    wait_all(40, "single_done");

    // Four requesters continuously valid, two rounds
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int unsigned i = 0; i < NR; i++) begin
        push_req(i, seq_ops(8'(1 + i)));
        expect_op(i, sums4[i]);
      end
    enable = 1'b1;
    wait_all(60, "rr_done");

    // Sole requester, back-to-back
    do_reset();
    peak = 0;
    for (int k = 1; k <= 10; k++) begin
      logic [7:0] b;
      b = 8'(k);
      push_req(1, {8{b}});
      expect_op(1, 8 * k);
    end
    enable = 1'b1;
    wait_all(60, "b2b_done");
    chk("b2b_cnt_peak", 64'(peak), 64'd6);

    // Drain with three in flight
    do_reset();
    push_req(0, {8{8'd10}});
    push_req(1, {8{8'd20}});
    push_req(3, {8{8'd30}});
    expect_op(0, 80);
    expect_op(1, 160);
    expect_op(3, 240);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (exp_grant.size() == 0) break;
    end
    enable = 1'b0;
    #2;
    push_req(2, {8{8'd5}});
    nb = n_grant;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dut.cnt_q == '0) break;
    end
    chk("drain_cnt_zero", 64'(dut.cnt_q), 64'd0);
    chk("drain_idle_at_zero", 64'(idle), 64'd0);
    @(negedge clk);
    chk("drain_idle_after", 64'(idle), 64'd1);
    chk("drain_rsps_left", 64'(exp_rsp.size()), 64'd0);
    chk("drain_new_grants", 64'(n_grant - nb), 64'd0);

    // Reset in the middle of a stream
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int unsigned i = 0; i < NR; i++) begin
        push_req(i, seq_ops(8'(1 + i)));
        expect_op(i, sums4[i]);
      end
    enable = 1'b1;
    repeat (5) @(posedge clk);
    do_reset();
    @(negedge clk);
    chk_reset("midrst");
    nb = n_rsp;
    repeat (12) @(negedge clk);
    chk("midrst_no_rsp", 64'(n_rsp - nb), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);

    // Spurious adder valid with an empty tag pipeline
    do_reset();
    @(posedge clk);
    #1;
    force_vo = 1'b1;
    @(posedge clk);
    #1;
    force_vo = 1'b0;
    @(negedge clk);
    chk("err_set", 64'(err), 64'd1);
    chk("err_no_rsp", 64'(bus.rsp_valid), 64'd0);
    repeat (5) @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);
    chk("err_still_no_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("err_idle", 64'(idle), 64'd1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
